// File: rtl/pcr_responder_if.sv
// PCR request/response bundle between a core (master) and a PCR target (slave).
interface pcr_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [63:0] req_data;
  logic [2:0]  req_we;
  logic        req_core_id;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_core_id;

  modport master (
    output req_valid, req_addr, req_data, req_we, req_core_id,
    input  req_ready, resp_valid, resp_data, resp_core_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, req_we, req_core_id,
    output req_ready, resp_valid, resp_data, resp_core_id
  );
endinterface

// File: rtl/pcr_responder.sv
// PCR target holding NUM_CNT 64-bit event counters with read/write/set/clear access.
// One request in flight: IDLE -> EXEC (access) -> RESP (one-cycle response pulse).
module pcr_responder #(
  parameter logic [11:0] BASE_ADDR = 12'h8C0,
  parameter int unsigned NUM_CNT   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pcr_responder_if.slave     pcr,
  input  logic [NUM_CNT-1:0] event_i
);

  localparam int unsigned IdxW = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e        state_q;
  logic          ready_q;
  logic          resp_valid_q;
  logic [63:0]   resp_data_q;
  logic          resp_core_id_q;
  logic [11:0]   addr_q;
  logic [63:0]   data_q;
  logic [2:0]    cmd_q;
  logic          core_id_q;
  logic [63:0]   cnt_q [NUM_CNT];
  logic [63:0]   cnt_d [NUM_CNT];

  logic [11:0]   offset;
  logic          hit;
  logic [IdxW-1:0] idx;
  logic [63:0]   cur_val;
  logic [63:0]   wr_val;
  logic          wr_cmd;
  logic          wr_en;

  // Unsigned offset compare plus lower bound keeps the window exact near 12'hFFF.
  assign offset  = addr_q - BASE_ADDR;
  assign hit     = (addr_q >= BASE_ADDR) && (offset < 12'(NUM_CNT));
  assign idx     = offset[IdxW-1:0];
  assign cur_val = cnt_q[idx];
  assign wr_cmd  = (cmd_q == 3'b001) || (cmd_q == 3'b010) || (cmd_q == 3'b011);
  assign wr_en   = (state_q == StExec) && hit && wr_cmd;

  always_comb begin
    wr_val = cur_val & ~data_q;
    case (cmd_q)
      3'b001:  wr_val = data_q;
      3'b010:  wr_val = cur_val | data_q;
      default: wr_val = cur_val & ~data_q;
    endcase
  end

  // A write-class access to a counter overrides its event strobe for that cycle.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      cnt_d[k] = cnt_q[k] + 64'(event_i[k]);
      if (wr_en && (idx == IdxW'(k))) begin
        cnt_d[k] = wr_val;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      ready_q        <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_core_id_q <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      cmd_q          <= '0;
      core_id_q      <= 1'b0;
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pcr.req_valid && ready_q) begin
            addr_q    <= pcr.req_addr;
            data_q    <= pcr.req_data;
            cmd_q     <= pcr.req_we;
            core_id_q <= pcr.req_core_id;
            ready_q   <= 1'b0;
            state_q   <= StExec;
          end
        end
        StExec: begin
          resp_data_q    <= hit ? cur_val : 64'd0;
          resp_core_id_q <= core_id_q;
          resp_valid_q   <= 1'b1;
          state_q        <= StResp;
        end
        StResp: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign pcr.req_ready    = ready_q;
  assign pcr.resp_valid   = resp_valid_q;
  assign pcr.resp_data    = resp_data_q;
  assign pcr.resp_core_id = resp_core_id_q;

endmodule

// File: tb/tb_pcr_responder.sv
// Bench for pcr_responder: directed scenarios plus random transactions checked
// against a cycle-level array model of the counters.
module tb_pcr_responder;

  localparam logic [11:0] Base   = 12'h8C0;
  localparam int          NumCnt = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] ev  = 8'h00;

  pcr_responder_if pcr ();

  pcr_responder #(
    .BASE_ADDR (Base),
    .NUM_CNT   (NumCnt)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .pcr     (pcr),
    .event_i (ev)
  );

  always #5 clk = ~clk;

  longint unsigned model [NumCnt];
  int              n_checks = 0;
  int              n_pass   = 0;
  bit              ev_rand  = 1'b0;
  logic [63:0]     got;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic next_ev();
    if (ev_rand) ev = 8'($urandom);
  endtask

  // One clock edge; the model applies events, then an optional access write that wins.
  task automatic tick(input bit wr, input int idx, input longint unsigned val);
    @(posedge clk);
    if (rst) begin
      foreach (model[k]) model[k] = 0;
    end else begin
      foreach (model[k]) if (ev[k] && !(wr && k == idx)) model[k] = model[k] + 1;
      if (wr) model[idx] = val;
    end
    @(negedge clk);
  endtask

  task automatic do_req(input logic [11:0] a, input logic [63:0] d, input logic [2:0] c,
                        input logic cid, output logic [63:0] resp);
    int              ai;
    int              idx;
    bit              hit;
    bit              wr;
    longint unsigned exp;
    longint unsigned newv;
    pcr.req_valid   = 1'b1;
    pcr.req_addr    = a;
    pcr.req_data    = d;
    pcr.req_we      = c;
    pcr.req_core_id = cid;
    next_ev();
    check_val("ready_idle", 64'(pcr.req_ready), 64'd1);
    tick(1'b0, 0, 0);
    // Scramble request inputs: only the accepted values may matter.
    pcr.req_valid   = 1'b0;
    pcr.req_addr    = 12'($urandom);
    pcr.req_data    = {$urandom, $urandom};
    pcr.req_we      = 3'($urandom);
    pcr.req_core_id = 1'($urandom);
    next_ev();
    check_val("ready_exec", 64'(pcr.req_ready), 64'd0);
    check_val("rv_exec", 64'(pcr.resp_valid), 64'd0);
    ai   = int'(a);
    hit  = (ai >= int'(Base)) && (ai < int'(Base) + NumCnt);
    idx  = hit ? ai - int'(Base) : 0;
    exp  = hit ? model[idx] : 0;
    wr   = hit && (c == 3'd1 || c == 3'd2 || c == 3'd3);
    newv = (c == 3'd1) ? d : (c == 3'd2) ? (model[idx] | d) : (model[idx] & ~d);
    tick(wr, idx, newv);
    check_val("rv_pulse", 64'(pcr.resp_valid), 64'd1);
    check_val("resp_data", pcr.resp_data, exp);
    check_val("resp_core_id", 64'(pcr.resp_core_id), 64'(cid));
    check_val("ready_resp", 64'(pcr.req_ready), 64'd0);
    next_ev();
    tick(1'b0, 0, 0);
    check_val("rv_after", 64'(pcr.resp_valid), 64'd0);
    check_val("ready_back", 64'(pcr.req_ready), 64'd1);
    check_val("resp_hold", pcr.resp_data, exp);
    resp = pcr.resp_data;
  endtask

  initial begin
    pcr.req_valid   = 1'b0;
    pcr.req_addr    = '0;
    pcr.req_data    = '0;
    pcr.req_we      = '0;
    pcr.req_core_id = 1'b0;
    foreach (model[k]) model[k] = 0;
    @(negedge clk);

    // Reset
    rst = 1'b1;
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);
    rst = 1'b0;
    check_val("rst_ready", 64'(pcr.req_ready), 64'd1);
    check_val("rst_rv", 64'(pcr.resp_valid), 64'd0);
    check_val("rst_data", pcr.resp_data, 64'd0);
    check_val("rst_cid", 64'(pcr.resp_core_id), 64'd0);
    do_req(Base, 64'd0, 3'd0, 1'b0, got);
    check_val("rst_read", got, 64'd0);

    // Write then read
    do_req(12'h8C3, 64'hDEAD_BEEF, 3'd1, 1'b1, got);
    check_val("wr_old", got, 64'd0);
    do_req(12'h8C3, 64'd0, 3'd0, 1'b1, got);
    check_val("wr_read", got, 64'hDEAD_BEEF);

    // Set / clear
    do_req(12'h8C1, 64'hF0, 3'd1, 1'b0, got);
    do_req(12'h8C1, 64'h0F, 3'd2, 1'b0, got);
    check_val("set_old", got, 64'hF0);
    do_req(12'h8C1, 64'h3C, 3'd3, 1'b1, got);
    check_val("clr_old", got, 64'hFF);
    do_req(12'h8C1, 64'd0, 3'd0, 1'b0, got);
    check_val("clr_read", got, 64'hC3);

    // Events and write/event collision
    ev = 8'h04;
    repeat (10) tick(1'b0, 0, 0);
    ev = 8'h00;
    do_req(12'h8C2, 64'd0, 3'd0, 1'b0, got);
    check_val("ev_count", got, 64'd10);
    ev = 8'h04;
    do_req(12'h8C2, 64'd5, 3'd1, 1'b0, got);
    ev = 8'h00;
    do_req(12'h8C2, 64'd0, 3'd0, 1'b0, got);
    check_val("collision", got, 64'd6);

    // Wrap and misses
    do_req(Base, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0, got);
    ev = 8'h01;
    tick(1'b0, 0, 0);
    ev = 8'h00;
    do_req(Base, 64'd0, 3'd0, 1'b0, got);
    check_val("wrap", got, 64'd0);
    do_req(12'h8C8, 64'd0, 3'd0, 1'b1, got);
    check_val("miss_read", got, 64'd0);
    do_req(12'h000, 64'h1234_5678, 3'd1, 1'b0, got);
    for (int k = 0; k < NumCnt; k++) do_req(Base + 12'(k), 64'd0, 3'd0, 1'b0, got);

    // Back-to-back with valid held high
    pcr.req_valid = 1'b1;
    pcr.req_addr  = 12'h8C5;
    pcr.req_we    = 3'd0;
    for (int i = 0; i < 9; i++) begin
      check_val("b2b_ready", 64'(pcr.req_ready), 64'((i % 3) == 0));
      check_val("b2b_rv", 64'(pcr.resp_valid), 64'((i % 3) == 2));
      tick(1'b0, 0, 0);
    end
    pcr.req_valid = 1'b0;

    // Reset during EXEC aborts the write
    do_req(12'h8C4, 64'd99, 3'd1, 1'b0, got);
    pcr.req_valid = 1'b1;
    pcr.req_addr  = 12'h8C4;
    pcr.req_data  = 64'd77;
    pcr.req_we    = 3'd1;
    tick(1'b0, 0, 0);
    pcr.req_valid = 1'b0;
    rst = 1'b1;
    tick(1'b0, 0, 0);
    rst = 1'b0;
    check_val("abort_rv", 64'(pcr.resp_valid), 64'd0);
    check_val("abort_ready", 64'(pcr.req_ready), 64'd1);
    tick(1'b0, 0, 0);
    check_val("abort_rv2", 64'(pcr.resp_valid), 64'd0);
    do_req(12'h8C4, 64'd0, 3'd0, 1'b0, got);
    check_val("abort_cnt", got, 64'd0);

    // Random traffic with random events
    ev_rand = 1'b1;
    repeat (150) begin
      int unsigned r;
      logic [11:0] a;
      r = $urandom_range(0, 9);
      a = (r < 9) ? Base + 12'(r) : 12'($urandom);
      do_req(a, {$urandom, $urandom}, 3'($urandom), 1'($urandom), got);
    end
    ev_rand = 1'b0;
    ev      = 8'h00;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
